shift_capture_ctrl: RTL

//   Sequences a serial-in/parallel-out shift register: captures a programmable

---
 rtl/shift_ctrl_pkg.sv | 19 +
 rtl/shift_capture_ctrl_shift_reg.sv | 40 ++++
 rtl/shift_capture_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/shift_ctrl_pkg.sv
// Shared definitions for the serial-capture controller.
//   state_t     : FSM state encoding (IDLE=0, SHIFT=1, HOLD=2)
//   WIDTH_DEF   : default capture width
//   cnt_width() : bits needed to hold a count of 0..w
package shift_ctrl_pkg;

   localparam int WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_capture_ctrl_shift_reg.sv
// shift_reg_en: serial-in/parallel-out shift register.
//   clk, rst : clock, async active-high reset (clears q)
//   clr      : synchronous clear, wins over en
//   en       : shift left one place, din enters bit 0
//   din      : serial input
//   q        : register contents
module shift_reg_en #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (clr) begin
         q_d = '0;
      end else if (en) begin
         q_d = {q_q[WIDTH-2:0], din};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/shift_capture_ctrl.sv
// shift_capture_ctrl: captures len serial bits (MSB first) per start command and
// presents the right-aligned word on a valid/ready port.
//   clk, rst   : clock, async active-high reset
//   start, len : capture command and bit count (legal 1..WIDTH)
//   din        : serial data, one bit per SHIFT-state edge
//   busy       : state != IDLE
//   out_data   : shift register contents, meaningful while out_valid
//   out_valid  : word held in HOLD
//   out_ready  : consumer accept
//   err        : one-cycle pulse after a start with illegal len
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | sampling din, cnt_q bits remaining
// HOLD  | word complete, waiting for out_ready
module shift_capture_ctrl
   import shift_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = cnt_width(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             din,
   output logic             busy,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             err
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             sr_clr;
   logic             sr_en;
   logic             len_ok;

   assign len_ok = (len != '0) && (len <= CNT_W'(WIDTH));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      sr_clr  = 1'b0;
      sr_en   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len_ok) begin
                  state_d = SHIFT;
                  cnt_d   = len;
                  sr_clr  = 1'b1;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SHIFT: begin
            sr_en = 1'b1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               state_d = HOLD;
            end
         end
         HOLD: begin
            // A start is only honoured on the accepting edge; otherwise the
            // word must stay put, so start without out_ready is dropped.
            if (out_ready) begin
               if (start && len_ok) begin
                  state_d = SHIFT;
                  cnt_d   = len;
                  sr_clr  = 1'b1;
               end else begin
                  state_d = IDLE;
                  err_d   = start;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   shift_reg_en #(
      .WIDTH(WIDTH)
   ) u_sr (
      .clk (clk),
      .rst (rst),
      .clr (sr_clr),
      .en  (sr_en),
      .din (din),
      .q   (out_data)
   );

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == HOLD);
   assign err       = err_q;

endmodule
